// File: rtl/jh_fifo_mem_pkg.sv
// Shared definitions for the interleaved FIFO memory responder.
//   MAX_READ_LATENCY : deepest supported read pipeline
//   bank_idx_t       : selects one of the two banks
//   bank_depth()     : words per bank for a given total FIFO depth
//   addr_width()     : width of the mem*_addr ports for a given FIFO depth
//   even_parity()    : even-parity bit over up to 64 data bits
package jh_fifo_mem_pkg;

  localparam int MAX_READ_LATENCY = 4;

  typedef logic bank_idx_t;

  function automatic int bank_depth(input int fifo_depth);
    return fifo_depth / 2;
  endfunction

  function automatic int addr_width(input int fifo_depth);
    return $clog2(fifo_depth);
  endfunction

  // Bit that makes the total count of ones even. Inputs wider than 64 bits
  // are truncated by the caller's cast; banks are expected to be narrower.
  function automatic logic even_parity(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/jh_fifo_mem_bank.sv
// One single-port synchronous RAM bank of the FIFO memory responder.
// Write-first on a same-cycle read/write, out-of-range accesses are dropped
// (reads return 0), sticky error flags and a saturating access counter.
// Optional per-word even parity when JH_FIFO_MEM_PARITY_EN is defined.
// Ports:
//   clk, rstn            clock, async active-low reset
//   addr, din            word address (full FIFO address width), write data
//   rd_en, wr_en         read / write request
//   clear                synchronous clear of flags and counter
//   parity_inject        invert stored parity on writes (parity build only)
//   dout                 read data, holds last delivered value
//   err_collision        sticky: rd_en and wr_en in the same cycle
//   err_range            sticky: access with addr >= bank depth
//   err_parity           sticky: parity mismatch on delivered read
//   acc_cnt              saturating count of accepted accesses
module jh_fifo_mem_bank
  import jh_fifo_mem_pkg::*;
#(
  parameter  int DATA_WIDTH   = 8,
  parameter  int FIFO_DEPTH   = 16,
  parameter  int READ_LATENCY = 1,
  parameter  int CNT_WIDTH    = 16,
  localparam int AW           = addr_width(FIFO_DEPTH),
  localparam int BD           = bank_depth(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic                  clear,
  input  logic                  parity_inject,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  err_collision,
  output logic                  err_range,
  output logic                  err_parity,
  output logic [CNT_WIDTH-1:0]  acc_cnt
);

  logic [DATA_WIDTH-1:0] mem [BD];
  logic [AW-2:0]         widx;
  logic                  in_range, wr_ok, rd_ok;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_perr;
  logic                  out_vld, out_perr;
  logic [DATA_WIDTH-1:0] out_dat;

  assign widx     = addr[AW-2:0];
  assign in_range = (addr < AW'(BD));
  assign wr_ok    = wr_en & in_range;
  assign rd_ok    = rd_en & in_range;

  // Array is deliberately not reset so contents survive rstn.
  always_ff @(posedge clk)
    if (wr_ok) mem[widx] <= din;

  // Write-first bypass on collision; out-of-range reads yield zero.
  always_comb begin
    rd_data = '0;
    if (in_range) rd_data = wr_en ? din : mem[widx];
  end

`ifdef JH_FIFO_MEM_PARITY_EN
  logic par_mem [BD];
  logic wr_par;

  assign wr_par = even_parity(64'(din)) ^ parity_inject;

  always_ff @(posedge clk)
    if (wr_ok) par_mem[widx] <= wr_par;

  // On a collision the bypassed word is checked against the bit being stored.
  assign rd_perr = rd_ok & (wr_en ? (wr_par != even_parity(64'(din)))
                                  : (par_mem[widx] != even_parity(64'(mem[widx]))));
`else
  logic unused_parity;
  assign unused_parity = parity_inject;
  assign rd_perr       = 1'b0;
`endif

  // READ_LATENCY-1 register stages ahead of the dout register.
  generate
    if (READ_LATENCY == 1) begin : g_direct
      assign out_vld  = rd_en;
      assign out_dat  = rd_data;
      assign out_perr = rd_perr;
    end else begin : g_pipe
      localparam int PS = READ_LATENCY - 1;
      logic [PS-1:0]                 vld_pipe;
      logic [PS-1:0]                 perr_pipe;
      logic [PS-1:0][DATA_WIDTH-1:0] dat_pipe;

      always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
          vld_pipe  <= '0;
          perr_pipe <= '0;
          dat_pipe  <= '0;
        end else begin
          vld_pipe[0]  <= rd_en;
          perr_pipe[0] <= rd_perr;
          dat_pipe[0]  <= rd_data;
          for (int i = 1; i < PS; i++) begin
            vld_pipe[i]  <= vld_pipe[i-1];
            perr_pipe[i] <= perr_pipe[i-1];
            dat_pipe[i]  <= dat_pipe[i-1];
          end
        end

      assign out_vld  = vld_pipe[PS-1];
      assign out_dat  = dat_pipe[PS-1];
      assign out_perr = perr_pipe[PS-1];
    end
  endgenerate

  // clear only affects flags and counter; data keeps flowing to dout.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      dout          <= '0;
      err_collision <= 1'b0;
      err_range     <= 1'b0;
      err_parity    <= 1'b0;
      acc_cnt       <= '0;
    end else begin
      if (out_vld) dout <= out_dat;
      if (clear) begin
        err_collision <= 1'b0;
        err_range     <= 1'b0;
        err_parity    <= 1'b0;
        acc_cnt       <= '0;
      end else begin
        if (rd_en & wr_en)               err_collision <= 1'b1;
        if ((rd_en | wr_en) & !in_range) err_range     <= 1'b1;
        if (out_vld & out_perr)          err_parity    <= 1'b1;
        if ((rd_ok | wr_ok) && (acc_cnt != '1))
          acc_cnt <= acc_cnt + CNT_WIDTH'(1);
      end
    end

endmodule

// File: rtl/jh_interleaved_fifo_mem_responder.sv
// Memory-side responder for the interleaved sync FIFO: two RAM banks serving
// the FIFO's mem0_*/mem1_* ports, with configurable read latency, sticky
// protocol-error flags and per-bank saturating access counters.
// Optional parity storage/checking: define JH_FIFO_MEM_PARITY_EN.
// Ports:
//   clk, rstn                      clock, async active-low reset
//   mem{0,1}_addr/_din             bank word address / write data
//   mem{0,1}_rd_enable/_wr_enable  bank read / write request
//   mem{0,1}_dout                  bank read data
//   clear                          sync clear of err_* and counters
//   parity_inject                  invert stored parity on writes
//   err_collision/err_range/err_parity  sticky flags, bit b = bank b
//   bank{0,1}_acc_cnt              saturating accepted-access counters
module jh_interleaved_fifo_mem_responder
  import jh_fifo_mem_pkg::*;
#(
  parameter  int DATA_WIDTH   = 8,
  parameter  int FIFO_DEPTH   = 16,
  parameter  int READ_LATENCY = 1,
  parameter  int CNT_WIDTH    = 16,
  localparam int AW           = addr_width(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [AW-1:0]         mem0_addr,
  input  logic [DATA_WIDTH-1:0] mem0_din,
  input  logic                  mem0_rd_enable,
  input  logic                  mem0_wr_enable,
  output logic [DATA_WIDTH-1:0] mem0_dout,
  input  logic [AW-1:0]         mem1_addr,
  input  logic [DATA_WIDTH-1:0] mem1_din,
  input  logic                  mem1_rd_enable,
  input  logic                  mem1_wr_enable,
  output logic [DATA_WIDTH-1:0] mem1_dout,
  input  logic                  clear,
  output logic [1:0]            err_collision,
  output logic [1:0]            err_range,
  output logic [1:0]            err_parity,
  input  logic                  parity_inject,
  output logic [CNT_WIDTH-1:0]  bank0_acc_cnt,
  output logic [CNT_WIDTH-1:0]  bank1_acc_cnt
);

  localparam bank_idx_t B0 = 1'b0;
  localparam bank_idx_t B1 = 1'b1;

  jh_fifo_mem_bank #(
    .DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH),
    .READ_LATENCY(READ_LATENCY), .CNT_WIDTH(CNT_WIDTH)
  ) u_bank0 (
    .clk(clk), .rstn(rstn),
    .addr(mem0_addr), .din(mem0_din),
    .rd_en(mem0_rd_enable), .wr_en(mem0_wr_enable),
    .clear(clear), .parity_inject(parity_inject),
    .dout(mem0_dout),
    .err_collision(err_collision[B0]), .err_range(err_range[B0]),
    .err_parity(err_parity[B0]), .acc_cnt(bank0_acc_cnt)
  );

  jh_fifo_mem_bank #(
    .DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH),
    .READ_LATENCY(READ_LATENCY), .CNT_WIDTH(CNT_WIDTH)
  ) u_bank1 (
    .clk(clk), .rstn(rstn),
    .addr(mem1_addr), .din(mem1_din),
    .rd_en(mem1_rd_enable), .wr_en(mem1_wr_enable),
    .clear(clear), .parity_inject(parity_inject),
    .dout(mem1_dout),
    .err_collision(err_collision[B1]), .err_range(err_range[B1]),
    .err_parity(err_parity[B1]), .acc_cnt(bank1_acc_cnt)
  );

endmodule
